pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central handshake and flush controller for the 5-stage in-order pipeline (IF, ID, EX, MEM, WB).
- Owns every stage valid bit and generates the allowin / x_to_y_valid chain that drives the inter-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Applies branch and exception flushes.
- Runs a small FSM that cancels an in-flight instruction-fetch response after a flush.
- Keeps stall and flush statistics counters.

Parameters:
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- pre_if_to_if_valid_i  in  1  PC-gen has a valid fetch for IF
- if_ready_go_i, id_ready_go_i, ex_ready_go_i, mem_ready_go_i, wb_ready_go_i  in  1 each  stage combinational work done
- br_flush_i  in  1  taken-branch redirect from EX
- excp_flush_i  in  1  exception/ertn redirect from WB
- inst_req_outstanding_i  in  1  IF has an inst-SRAM request accepted, data not yet returned
- inst_rdata_ok_i  in  1  inst-SRAM data return this cycle
- if_allowin_o, id_allowin_o, ex_allowin_o, mem_allowin_o, wb_allowin_o  out  1 each  stage may accept new data
- if_valid_o, id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o  out  1 each  stage holds a live instruction
- if_to_id_valid_o, id_to_ex_valid_o, ex_to_mem_valid_o, mem_to_wb_valid_o  out  1 each  producer-side valid toward the next stage
- if_discard_o  out  1  next inst response must be dropped by IF
- stall_cnt_o  out  CNT_W  cycles with any live stage not ready_go
- flush_cnt_o  out  CNT_W  number of flush events

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. On reset:
  - all *_valid_o = 0
  - FSM = RUN, if_discard_o = 0
  - both counters = 0
  - reset overrides all other inputs in that cycle.
- Qualified flush events:
  - excp = excp_flush_i && wb_valid.
  - br = br_flush_i && ex_valid && ex_ready_go_i && !excp. Exception has priority.
- Allowin (combinational):
  - wb_allowin = !wb_valid || wb_ready_go_i.
  - x_allowin = !x_valid || (x_ready_go && next_allowin), for MEM, EX, ID.
  - if_allowin: same rule, additionally forced 0 while FSM = CANCEL.
- Forward valid (combinational):
  - x_to_y_valid = x_valid && x_ready_go && !kill_x.
  - excp kills all stages; br kills IF and ID.
- Valid registers, per stage each cycle, in priority order:
  - killed → 0;
  - else if x_allowin → prev_to_x_valid (IF takes pre_if_to_if_valid_i);
  - else hold.
- Flush effects:
  - excp clears IF..WB valid next cycle; the excepting WB instruction does not commit.
  - br clears IF and ID valid only. The branch in EX still advances into MEM if mem_allowin.
- Latency: a flush takes effect on the next clock edge; no bubble insertion beyond the cleared stages.
- Cancel FSM, states RUN and CANCEL:
  - RUN → CANCEL when (excp || br) && inst_req_outstanding_i && !inst_rdata_ok_i.
  - CANCEL → RUN on inst_rdata_ok_i.
  - A flush while in CANCEL stays in CANCEL; at most one request is ever outstanding.
  - if_discard_o = (state == CANCEL), registered.
  - A flush in the same cycle as inst_rdata_ok_i does not enter CANCEL; that data is already killed via IF valid.
- Counters:
  - stall_cnt_o increments when any stage has x_valid && !x_ready_go.
  - flush_cnt_o increments by 1 per cycle with excp || br. Simultaneous excp+br counts once.
  - Both saturate at all-ones; no wrap.
- Boundary cases:
  - Back-pressure chain: when WB stalls, MEM holds if MEM is valid and ready; the condition propagates up-stream within the same cycle (combinational).
  - Empty stage always allows in.
  - Reset asserted mid-CANCEL returns the FSM to RUN, discard = 0.

Decomposition:
- Shared package/header gets:
  - stage index constants (IF = 0 .. WB = 4)
  - FSM state encodings CTRL_RUN / CTRL_CANCEL
  - CNT_W default
  - RstEnable reuse
- One sub-module, sat_counter (width-parameterised, enable, saturating), instantiated twice for the statistics counters.
- Allowin/valid chain stays flat in pipe_ctrl.

Test Plan:
1. Free flow: all ready_go = 1, pre_if valid every cycle from reset release → IF..WB valid rise on cycles 1..5; all allowin = 1; stall_cnt_o = 0.
2. WB stall: wb_ready_go_i = 0 for 3 cycles with a full pipe → wb_allowin..if_allowin all 0 for those cycles; all valids held; stall_cnt_o = 3; flow resumes the cycle after release.
3. Branch flush: br_flush_i = 1 with ex_valid, no fetch outstanding → next cycle if_valid = id_valid = 0, mem_valid = 1 (branch advanced); flush_cnt_o = 1; FSM stays RUN.
4. Exception during outstanding fetch: excp_flush_i with wb_valid and inst_req_outstanding_i = 1, inst_rdata_ok_i = 0 → all valids 0 next cycle; if_discard_o = 1 and if_allowin_o = 0 until inst_rdata_ok_i, then 0/1 the cycle after.
5. excp and br in the same cycle → excp behaviour only (all stages cleared); flush_cnt_o increments by exactly 1.
6. Saturation and reset: preload stall_cnt_o near all-ones (CNT_W = 4, force stalls 20 cycles) → holds at 15; then assert rst_n = 0 in CANCEL → next cycle all outputs at reset values.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline handshake/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;
  localparam int unsigned NUM_STG = 5;

  localparam int unsigned CNT_W_DEF = 32;

  localparam logic RstEnable = 1'b0;

  typedef enum logic {
    CTRL_RUN    = 1'b0,
    CTRL_CANCEL = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             pre_if_to_if_valid_i;
  logic             if_ready_go_i, id_ready_go_i, ex_ready_go_i, mem_ready_go_i, wb_ready_go_i;
  logic             br_flush_i;
  logic             excp_flush_i;
  logic             inst_req_outstanding_i;
  logic             inst_rdata_ok_i;
  logic             if_allowin_o, id_allowin_o, ex_allowin_o, mem_allowin_o, wb_allowin_o;
  logic             if_valid_o, id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o;
  logic             if_to_id_valid_o, id_to_ex_valid_o, ex_to_mem_valid_o, mem_to_wb_valid_o;
  logic             if_discard_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output pre_if_to_if_valid_i,
    output if_ready_go_i, id_ready_go_i, ex_ready_go_i, mem_ready_go_i, wb_ready_go_i,
    output br_flush_i, excp_flush_i, inst_req_outstanding_i, inst_rdata_ok_i,
    input  if_allowin_o, id_allowin_o, ex_allowin_o, mem_allowin_o, wb_allowin_o,
    input  if_valid_o, id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o,
    input  if_to_id_valid_o, id_to_ex_valid_o, ex_to_mem_valid_o, mem_to_wb_valid_o,
    input  if_discard_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  pre_if_to_if_valid_i,
    input  if_ready_go_i, id_ready_go_i, ex_ready_go_i, mem_ready_go_i, wb_ready_go_i,
    input  br_flush_i, excp_flush_i, inst_req_outstanding_i, inst_rdata_ok_i,
    output if_allowin_o, id_allowin_o, ex_allowin_o, mem_allowin_o, wb_allowin_o,
    output if_valid_o, id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o,
    output if_to_id_valid_o, id_to_ex_valid_o, ex_to_mem_valid_o, mem_to_wb_valid_o,
    output if_discard_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Enable-gated up counter that sticks at all-ones instead of wrapping.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stage valid/allowin chain, branch/exception flush, fetch-cancel FSM and
// stall/flush statistics for the 5-stage pipeline.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_ctrl_if.slave    bus
);

  logic [NUM_STG-1:0] valid_q, valid_d, ready_go, allowin, kill, in_valid;
  logic [NUM_STG-2:0] to_valid;
  logic               excp, br, flush;
  logic               wb_allowin, mem_allowin, ex_allowin, id_allowin, if_allowin;
  ctrl_state_e        state_q, state_d;

  assign ready_go = {bus.wb_ready_go_i, bus.mem_ready_go_i, bus.ex_ready_go_i,
                     bus.id_ready_go_i, bus.if_ready_go_i};

  // Exception wins; a branch is only honoured if it actually leaves EX.
  assign excp  = bus.excp_flush_i && valid_q[STG_WB];
  assign br    = bus.br_flush_i && valid_q[STG_EX] && ready_go[STG_EX] && !excp;
  assign flush = excp || br;
  assign kill  = excp ? '1 : (br ? 5'b00011 : '0);

  // Back-pressure ripples upstream combinationally from WB.
  assign wb_allowin  = !valid_q[STG_WB]  || ready_go[STG_WB];
  assign mem_allowin = !valid_q[STG_MEM] || (ready_go[STG_MEM] && wb_allowin);
  assign ex_allowin  = !valid_q[STG_EX]  || (ready_go[STG_EX]  && mem_allowin);
  assign id_allowin  = !valid_q[STG_ID]  || (ready_go[STG_ID]  && ex_allowin);
  assign if_allowin  = (!valid_q[STG_IF] || (ready_go[STG_IF] && id_allowin)) &&
                       (state_q != CTRL_CANCEL);
  assign allowin = {wb_allowin, mem_allowin, ex_allowin, id_allowin, if_allowin};

  assign to_valid = valid_q[NUM_STG-2:0] & ready_go[NUM_STG-2:0] & ~kill[NUM_STG-2:0];
  assign in_valid = {to_valid, bus.pre_if_to_if_valid_i};
  assign valid_d  = ~kill & ((allowin & in_valid) | (~allowin & valid_q));

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      valid_q <= '0;
      state_q <= CTRL_RUN;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  // Data returning in the flush cycle is already dropped via IF valid,
  // so only a still-pending response needs to be cancelled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_RUN:
        if (flush && bus.inst_req_outstanding_i && !bus.inst_rdata_ok_i) state_d = CTRL_CANCEL;
      CTRL_CANCEL:
        if (bus.inst_rdata_ok_i) state_d = CTRL_RUN;
      default: state_d = CTRL_RUN;
    endcase
  end

  assign bus.if_discard_o = (state_q == CTRL_CANCEL);

  assign bus.wb_allowin_o  = wb_allowin;
  assign bus.mem_allowin_o = mem_allowin;
  assign bus.ex_allowin_o  = ex_allowin;
  assign bus.id_allowin_o  = id_allowin;
  assign bus.if_allowin_o  = if_allowin;

  assign bus.if_valid_o  = valid_q[STG_IF];
  assign bus.id_valid_o  = valid_q[STG_ID];
  assign bus.ex_valid_o  = valid_q[STG_EX];
  assign bus.mem_valid_o = valid_q[STG_MEM];
  assign bus.wb_valid_o  = valid_q[STG_WB];

  assign bus.if_to_id_valid_o  = to_valid[STG_IF];
  assign bus.id_to_ex_valid_o  = to_valid[STG_ID];
  assign bus.ex_to_mem_valid_o = to_valid[STG_EX];
  assign bus.mem_to_wb_valid_o = to_valid[STG_MEM];

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (|(valid_q & ~ready_go)),
    .cnt   (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush),
    .cnt   (bus.flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl with 4-bit statistics counters.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W = 4;

  typedef struct {
    logic       pre;
    logic [4:0] rg;
    logic       br, excp, outs, rok;
    logic [4:0] allowin;
    logic [4:0] valid;
    logic [3:0] tv;
    logic       disc;
    logic [3:0] stall;
    logic [3:0] flush;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tab[$];

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [4:0] get_allowin();
    return {bus.wb_allowin_o, bus.mem_allowin_o, bus.ex_allowin_o, bus.id_allowin_o, bus.if_allowin_o};
  endfunction

  function automatic logic [4:0] get_valid();
    return {bus.wb_valid_o, bus.mem_valid_o, bus.ex_valid_o, bus.id_valid_o, bus.if_valid_o};
  endfunction

  function automatic logic [3:0] get_tv();
    return {bus.mem_to_wb_valid_o, bus.ex_to_mem_valid_o, bus.id_to_ex_valid_o, bus.if_to_id_valid_o};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pre, input logic [4:0] rg, input logic br,
                       input logic excp, input logic outs, input logic rok);
    bus.pre_if_to_if_valid_i   = pre;
    bus.if_ready_go_i          = rg[0];
    bus.id_ready_go_i          = rg[1];
    bus.ex_ready_go_i          = rg[2];
    bus.mem_ready_go_i         = rg[3];
    bus.wb_ready_go_i          = rg[4];
    bus.br_flush_i             = br;
    bus.excp_flush_i           = excp;
    bus.inst_req_outstanding_i = outs;
    bus.inst_rdata_ok_i        = rok;
  endtask

  task automatic add(input logic pre, input logic [4:0] rg, input logic br, input logic excp,
                     input logic outs, input logic rok, input logic [4:0] al, input logic [4:0] v,
                     input logic [3:0] tv, input logic disc, input logic [3:0] st, input logic [3:0] fl);
    tab.push_back('{pre, rg, br, excp, outs, rok, al, v, tv, disc, st, fl});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    //   pre rg     br excp out rok | allowin valid tv   disc stall flush
    // free flow from reset release
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h00, 4'h0, 0, 4'd0, 4'd0);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h01, 4'h1, 0, 4'd0, 4'd0);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h03, 4'h3, 0, 4'd0, 4'd0);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h07, 4'h7, 0, 4'd0, 4'd0);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h0F, 4'hF, 0, 4'd0, 4'd0);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h1F, 4'hF, 0, 4'd0, 4'd0);
    // WB stalls three cycles, then releases
    add(1, 5'h0F, 0, 0, 0, 0, 5'h00, 5'h1F, 4'hF, 0, 4'd0, 4'd0);
    add(1, 5'h0F, 0, 0, 0, 0, 5'h00, 5'h1F, 4'hF, 0, 4'd1, 4'd0);
    add(1, 5'h0F, 0, 0, 0, 0, 5'h00, 5'h1F, 4'hF, 0, 4'd2, 4'd0);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h1F, 4'hF, 0, 4'd3, 4'd0);
    // branch flush, nothing outstanding
    add(1, 5'h1F, 1, 0, 0, 0, 5'h1F, 5'h1F, 4'hC, 0, 4'd3, 4'd0);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h18, 4'h8, 0, 4'd3, 4'd1);
    // exception with a fetch outstanding -> CANCEL until data returns
    add(1, 5'h1F, 0, 1, 1, 0, 5'h1F, 5'h11, 4'h0, 0, 4'd3, 4'd1);
    add(1, 5'h1F, 0, 0, 1, 0, 5'h1E, 5'h00, 4'h0, 1, 4'd3, 4'd2);
    add(1, 5'h1F, 0, 0, 1, 1, 5'h1E, 5'h00, 4'h0, 1, 4'd3, 4'd2);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h00, 4'h0, 0, 4'd3, 4'd2);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h01, 4'h1, 0, 4'd3, 4'd2);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h03, 4'h3, 0, 4'd3, 4'd2);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h07, 4'h7, 0, 4'd3, 4'd2);
    add(1, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h0F, 4'hF, 0, 4'd3, 4'd2);
    // simultaneous exception and branch
    add(1, 5'h1F, 1, 1, 0, 0, 5'h1F, 5'h1F, 4'h0, 0, 4'd3, 4'd2);
    add(0, 5'h1F, 0, 0, 0, 0, 5'h1F, 5'h00, 4'h0, 0, 4'd3, 4'd3);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tab.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(tab[i].pre, tab[i].rg, tab[i].br, tab[i].excp, tab[i].outs, tab[i].rok);
      #1;
      check($sformatf("row%0d allowin", i), 32'(get_allowin()), 32'(tab[i].allowin));
      check($sformatf("row%0d valid", i), 32'(get_valid()), 32'(tab[i].valid));
      check($sformatf("row%0d to_valid", i), 32'(get_tv()), 32'(tab[i].tv));
      check($sformatf("row%0d discard", i), 32'(bus.if_discard_o), 32'(tab[i].disc));
      check($sformatf("row%0d stall_cnt", i), 32'(bus.stall_cnt_o), 32'(tab[i].stall));
      check($sformatf("row%0d flush_cnt", i), 32'(bus.flush_cnt_o), 32'(tab[i].flush));
    end

    // Saturation: refill, stall WB for 20 cycles, stall counter pins at 15.
    @(negedge clk);
    drive(1, 5'h1F, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    #1;
    check("sat fill valid", 32'(get_valid()), 32'h1F);
    drive(1, 5'h0F, 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    #1;
    check("sat stall_cnt", 32'(bus.stall_cnt_o), 32'd15);
    check("sat allowin", 32'(get_allowin()), 32'h00);
    check("sat valid hold", 32'(get_valid()), 32'h1F);

    // Exception with pending fetch, then reset while in CANCEL.
    drive(1, 5'h0F, 0, 1, 1, 0);
    @(negedge clk);
    #1;
    drive(1, 5'h0F, 0, 0, 1, 0);
    check("cancel discard", 32'(bus.if_discard_o), 32'd1);
    check("cancel valid", 32'(get_valid()), 32'h00);
    check("cancel if_allowin", 32'(bus.if_allowin_o), 32'd0);
    check("cancel flush_cnt", 32'(bus.flush_cnt_o), 32'd4);
    check("cancel stall_cnt", 32'(bus.stall_cnt_o), 32'd15);
    @(negedge clk);
    #1;
    check("cancel held", 32'(bus.if_discard_o), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("rst discard", 32'(bus.if_discard_o), 32'd0);
    check("rst valid", 32'(get_valid()), 32'h00);
    check("rst stall_cnt", 32'(bus.stall_cnt_o), 32'd0);
    check("rst flush_cnt", 32'(bus.flush_cnt_o), 32'd0);
    check("rst allowin", 32'(get_allowin()), 32'h1F);

    // Branch in the same cycle as the data return must not enter CANCEL.
    drive(1, 5'h1F, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("brok fill valid", 32'(get_valid()), 32'h07);
    drive(1, 5'h1F, 1, 0, 1, 1);
    @(negedge clk);
    #1;
    drive(1, 5'h1F, 0, 0, 0, 0);
    check("brok valid", 32'(get_valid()), 32'h08);
    check("brok discard", 32'(bus.if_discard_o), 32'd0);
    check("brok if_allowin", 32'(bus.if_allowin_o), 32'd1);
    check("brok flush_cnt", 32'(bus.flush_cnt_o), 32'd1);
    check("brok stall_cnt", 32'(bus.stall_cnt_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
